// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control FSM with memory-wait timeout and sticky trap.
module mc_ctrl #(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               MemAck,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               MemReq,
   output logic               MemWrite,
   output logic               IorD,
   output logic               ALUSrc,
   output logic               EXTOp,
   output logic               AregSel,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         NPCOp,
   output logic [1:0]         GPRSel,
   output logic [1:0]         WDSel,
   output logic [2:0]         State,
   output logic               Trap,
   output logic [1:0]         TrapCause
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd7
   } state_e;
   localparam logic [3:0] A_NOP = 4'h0, A_ADD = 4'h1, A_SUB = 4'h2, A_AND = 4'h3,
                          A_OR  = 4'h4, A_SLT = 4'h5, A_SLTU = 4'h6, A_SLL = 4'h7,
                          A_SRL = 4'h8, A_SRA = 4'h9, A_NOR = 4'hA, A_XOR = 4'hB,
                          A_LUI = 4'hC;
   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] cause_q, cause_d;
   logic       sw_q, sw_d;
   logic       legal, dec_src, dec_ext, dec_areg, taken, timeout;
   logic [3:0] dec_alu;
   logic       is_beq, is_bne, is_j, is_jal, is_jr, is_jalr, is_lw, is_sw, is_imm;

   assign is_beq  = Op == 6'h04;
   assign is_bne  = Op == 6'h05;
   assign is_j    = Op == 6'h02;
   assign is_jal  = Op == 6'h03;
   assign is_jr   = Op == 6'h00 && Funct == 6'h08;
   assign is_jalr = Op == 6'h00 && Funct == 6'h09;
   assign is_lw   = Op == 6'h23;
   assign is_sw   = Op == 6'h2B;
   assign is_imm  = Op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
   assign taken   = is_beq ? Zero : !Zero;
   assign timeout = cnt_q == 8'(MEM_TIMEOUT - 1);
   assign State   = state_q;
   assign TrapCause = cause_q;

   always_comb begin
      legal    = 1'b1;
      dec_alu  = A_NOP;
      dec_src  = 1'b0;
      dec_ext  = 1'b0;
      dec_areg = 1'b0;
      if (Op == 6'h00) begin
         case (Funct)
            6'h20, 6'h21: dec_alu = A_ADD;
            6'h22, 6'h23: dec_alu = A_SUB;
            6'h24:        dec_alu = A_AND;
            6'h25:        dec_alu = A_OR;
            6'h26:        dec_alu = A_XOR;
            6'h27:        dec_alu = A_NOR;
            6'h2A:        dec_alu = A_SLT;
            6'h2B:        dec_alu = A_SLTU;
            6'h00:        {dec_alu, dec_areg} = {A_SLL, 1'b1};
            6'h02:        {dec_alu, dec_areg} = {A_SRL, 1'b1};
            6'h03:        {dec_alu, dec_areg} = {A_SRA, 1'b1};
            6'h04:        dec_alu = A_SLL;
            6'h06:        dec_alu = A_SRL;
            6'h07:        dec_alu = A_SRA;
            6'h08, 6'h09: dec_alu = A_NOP;
            default:      legal = 1'b0;
         endcase
      end else begin
         case (Op)
            6'h08:        {dec_alu, dec_src, dec_ext} = {A_ADD, 2'b11};
            6'h0A:        {dec_alu, dec_src, dec_ext} = {A_SLT, 2'b11};
            6'h0C:        {dec_alu, dec_src, dec_ext} = {A_AND, 2'b10};
            6'h0D:        {dec_alu, dec_src, dec_ext} = {A_OR, 2'b10};
            6'h0F:        {dec_alu, dec_src, dec_ext} = {A_LUI, 2'b10};
            6'h23, 6'h2B: {dec_alu, dec_src, dec_ext} = {A_ADD, 2'b11};
            6'h04, 6'h05: {dec_alu, dec_src, dec_ext} = {A_SUB, 2'b01};
            6'h02, 6'h03: dec_alu = A_NOP;
            default:      legal = 1'b0;
         endcase
      end
   end

   // Outputs are forced low while rstn is held so no request escapes the reset cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = 8'd0;
      cause_d  = cause_q;
      sw_d     = sw_q;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      ALUSrc   = 1'b0;
      EXTOp    = 1'b0;
      AregSel  = 1'b0;
      ALUOp    = '0;
      NPCOp    = 2'b00;
      GPRSel   = 2'b00;
      WDSel    = 2'b00;
      Trap     = 1'b0;
      if (rstn) begin
         case (state_q)
            FETCH: begin
               MemReq = 1'b1;
               if (MemAck) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  state_d = DECODE;
               end else if (timeout) begin
                  state_d = TRAP;
                  cause_d = 2'b10;
               end else cnt_d = cnt_q + 8'd1;
            end
            DECODE: begin
               state_d = legal ? EXEC : TRAP;
               cause_d = legal ? cause_q : 2'b01;
            end
            EXEC: begin
               ALUOp   = ALUOP_W'(dec_alu);
               ALUSrc  = dec_src;
               EXTOp   = dec_ext;
               AregSel = dec_areg;
               sw_d    = is_sw;
               state_d = WB;
               if (is_beq || is_bne) begin
                  PCWrite = taken;
                  NPCOp   = taken ? 2'b01 : 2'b00;
                  state_d = FETCH;
               end else if (is_j || is_jal) begin
                  PCWrite = 1'b1;
                  NPCOp   = 2'b10;
                  state_d = is_j ? FETCH : WB;
               end else if (is_jr || is_jalr) begin
                  PCWrite = 1'b1;
                  NPCOp   = 2'b11;
                  state_d = is_jr ? FETCH : WB;
               end else if (is_lw || is_sw) state_d = MEM;
            end
            MEM: begin
               MemReq   = 1'b1;
               IorD     = 1'b1;
               MemWrite = sw_q;
               ALUOp    = ALUOP_W'(A_ADD);
               ALUSrc   = 1'b1;
               EXTOp    = 1'b1;
               if (MemAck) state_d = sw_q ? FETCH : WB;
               else if (timeout) begin
                  state_d = TRAP;
                  cause_d = 2'b10;
               end else cnt_d = cnt_q + 8'd1;
            end
            WB: begin
               RegWrite = 1'b1;
               GPRSel   = is_jal ? 2'b10 : (is_imm || is_lw) ? 2'b01 : 2'b00;
               WDSel    = is_lw ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
               state_d  = FETCH;
            end
            TRAP:    Trap = 1'b1;
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= FETCH;
         cnt_q   <= 8'd0;
         cause_q <= 2'b00;
         sw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         sw_q    <= sw_d;
      end
   end
endmodule
